// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: holds the PC, computes PC + INSTR_BYTES,
// arbitrates exception/redirect sources and presents a valid/ready fetch
// request to instruction memory.
module pc_fetch_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter int unsigned       INSTR_BYTES  = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             fetch_valid,
  output logic             misalign_err,
  output logic             redirected
);

  // Low address bits that must be zero for an instruction-aligned target.
  // With INSTR_BYTES = 1 the mask is zero and every target is aligned.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
  localparam logic [WIDTH-1:0] STRIDE     = WIDTH'(INSTR_BYTES);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             misalign_reg, misalign_next;
  logic             redirected_reg, redirected_next;

  logic             fire;
  logic             jump;
  logic             target_misaligned;

  assign fire              = imem_ready & ~stall;
  assign jump              = exc_valid | redirect_valid;
  assign target_misaligned = (redirect_target & ALIGN_MASK) != '0;

  // State, PC and event-pulse registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_VECTOR;
      misalign_reg   <= 1'b0;
      redirected_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      misalign_reg   <= misalign_next;
      redirected_reg <= redirected_next;
    end
  end

  // Next-state and next-PC selection; exceptions beat redirects beat fire,
  // and redirect sources ignore stall/imem_ready (a pending fetch is dropped).
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    misalign_next   = 1'b0;
    redirected_next = 1'b0;
    unique case (state_reg)
      BOOT: begin
        // Redirect/exception inputs are deliberately ignored here.
        state_next = RUN;
      end
      RUN, WAIT: begin
        if (exc_valid) begin
          pc_next         = EXC_VECTOR;
          redirected_next = 1'b1;
        end else if (redirect_valid && target_misaligned) begin
          pc_next         = EXC_VECTOR;
          misalign_next   = 1'b1;
          redirected_next = 1'b1;
        end else if (redirect_valid) begin
          pc_next         = redirect_target;
          redirected_next = 1'b1;
        end else if (fire) begin
          pc_next = pc_plus;
        end
        // WAIT holds the address stable until it is accepted or replaced.
        state_next = (fire || jump) ? RUN : WAIT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Sequential successor wraps modulo 2^WIDTH; carry-out is discarded.
  assign pc_plus      = pc_reg + STRIDE;
  assign pc           = pc_reg;
  assign fetch_valid  = (state_reg != BOOT);
  assign misalign_err = misalign_reg;
  assign redirected   = redirected_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expectations are queued when stimulus is
// driven and popped/compared after the following rising edge.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        imem_ready;

  logic [31:0] pc, pc_plus;
  logic        fetch_valid, misalign_err, redirected;

  // Second instance with a 2-byte stride to check per-parameter alignment.
  logic [31:0] pc2, pc_plus2;
  logic        fetch_valid2, misalign_err2, redirected2;

  pc_fetch_unit #(.WIDTH(32), .INSTR_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .imem_ready(imem_ready),
    .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid),
    .misalign_err(misalign_err), .redirected(redirected)
  );

  pc_fetch_unit #(.WIDTH(32), .INSTR_BYTES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .imem_ready(imem_ready),
    .pc(pc2), .pc_plus(pc_plus2), .fetch_valid(fetch_valid2),
    .misalign_err(misalign_err2), .redirected(redirected2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic        red;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  task automatic push(input string tag, input logic [31:0] e_pc,
                      input logic e_fv, input logic e_mis, input logic e_red);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.fv = e_fv; e.mis = e_mis; e.red = e_red;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the primary DUT now.
  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".pc"},       pc,                  e.pc);
    chk({e.tag, ".pc_plus"},  pc_plus,             e.pc + 32'd4);
    chk({e.tag, ".fv"},       {31'd0, fetch_valid}, {31'd0, e.fv});
    chk({e.tag, ".mis"},      {31'd0, misalign_err}, {31'd0, e.mis});
    chk({e.tag, ".red"},      {31'd0, redirected},  {31'd0, e.red});
    $display("txn %-12s pc=0x%08h fv=%0b mis=%0b red=%0b", e.tag, pc, fetch_valid, misalign_err, redirected);
  endtask

  // Queue the post-edge expectation, advance one edge, then compare.
  task automatic cycle(input string tag, input logic [31:0] e_pc,
                       input logic e_fv, input logic e_mis, input logic e_red);
    push(tag, e_pc, e_fv, e_mis, e_red);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; exc_valid = 1'b0; imem_ready = 1'b1;

    // Held in reset across edges.
    repeat (2) @(posedge clk);
    #1;
    push("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    pop_check();

    // Release reset away from the edge: BOOT cycle then sequential fetch.
    rst_n = 1'b1;
    push("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    pop_check();
    cycle("boot_exit", 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) cycle("seq", 32'(i * 4), 1'b1, 1'b0, 1'b0);

    // Stall at 0x10 for three edges, then resume.
    stall = 1'b1;
    repeat (3) cycle("stall", 32'h10, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    cycle("unstall", 32'h14, 1'b1, 1'b0, 1'b0);
    cycle("seq", 32'h18, 1'b1, 1'b0, 1'b0);
    cycle("seq", 32'h1C, 1'b1, 1'b0, 1'b0);
    cycle("seq", 32'h20, 1'b1, 1'b0, 1'b0);

    // Memory not ready: address must stay put.
    imem_ready = 1'b0;
    cycle("not_ready", 32'h20, 1'b1, 1'b0, 1'b0);

    // Redirect overrides stall and not-ready.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
    cycle("redirect", 32'h100, 1'b1, 1'b0, 1'b1);
    redirect_valid = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    cycle("post_redir", 32'h104, 1'b1, 1'b0, 1'b0);

    // Exception beats a simultaneous redirect.
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    cycle("exc_prio", 32'h80, 1'b1, 1'b0, 1'b1);
    exc_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b1;
    cycle("post_exc", 32'h80, 1'b1, 1'b0, 1'b0);

    // Misaligned for a 4-byte stride, aligned for a 2-byte stride.
    redirect_valid = 1'b1; redirect_target = 32'h102;
    cycle("misalign", 32'h80, 1'b1, 1'b1, 1'b1);
    chk("i2.pc", pc2, 32'h102);
    chk("i2.mis", {31'd0, misalign_err2}, 32'd0);
    chk("i2.red", {31'd0, redirected2}, 32'd1);
    redirect_valid = 1'b0;
    cycle("mis_clear", 32'h80, 1'b1, 1'b0, 1'b0);

    // Wrap-around of the sequential successor.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    cycle("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
    redirect_valid = 1'b0; stall = 1'b0;
    cycle("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset asserted mid-cycle while a redirect is requested.
    redirect_valid = 1'b1; redirect_target = 32'h300;
    #2 rst_n = 1'b0;
    #1;
    push("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    pop_check();
    cycle("in_reset", 32'h0, 1'b0, 1'b0, 1'b0);

    // Redirect stays asserted through BOOT and must be ignored there.
    rst_n = 1'b1;
    cycle("boot_ignore", 32'h0, 1'b1, 1'b0, 1'b0);
    cycle("redir_run", 32'h300, 1'b1, 1'b0, 1'b1);
    redirect_valid = 1'b0;
    cycle("after_run", 32'h304, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
